// File: rtl/seg_store_ctrl.sv
// Segment store controller: block-copies words between local working memory and the backing store
// for SAVE/LOAD commands. Optional XOR transfer checksum enabled by defining STORE_CHECKSUM_EN.
module seg_store_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SEG_W  = 8,
  parameter int unsigned OFF_W  = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   store_write,
  input  logic                   store_read,
  input  logic [SEG_W-1:0]       SA,
  input  logic [SEG_W-1:0]       SB,
  input  logic [SEG_W-1:0]       SC,
  output logic                   store_busy,
  output logic [SEG_W+OFF_W-1:0] loc_addr,
  output logic                   loc_we,
  output logic [DATA_W-1:0]      loc_wdata,
  input  logic [DATA_W-1:0]      loc_rdata,
  output logic                   bk_req,
  output logic                   bk_we,
  output logic [SEG_W+OFF_W-1:0] bk_addr,
  output logic [DATA_W-1:0]      bk_wdata,
  input  logic [DATA_W-1:0]      bk_rdata,
  input  logic                   bk_ack,
  output logic [DATA_W-1:0]      chk
);

  localparam int unsigned CntW = OFF_W + 1;
  localparam logic [CntW-1:0]  SegWords   = CntW'(2 ** OFF_W);
  localparam logic [SEG_W-1:0] SegWordsSc = SEG_W'(2 ** OFF_W);

  typedef enum logic [2:0] {
    StIdle, StLRd, StLWait, StBWr, StBRd, StLWr, StDone
  } state_e;

  state_e            r_state, w_state_d;
  logic [SEG_W-1:0]  r_sa, r_sb;
  logic [CntW-1:0]   r_n, r_cnt;
  logic [DATA_W-1:0] r_data_q;

  logic              w_cmd, w_start, w_last;
  logic [CntW-1:0]   w_n_in;

  assign w_cmd   = store_write | store_read;
  assign w_start = (r_state == StIdle) && w_cmd;
  // Counter is one bit wider than the offset so a full segment never wraps.
  assign w_n_in  = (SC >= SegWordsSc) ? SegWords : SC[CntW-1:0];
  assign w_last  = (r_cnt + CntW'(1)) == r_n;

  assign loc_addr  = {r_sa, r_cnt[OFF_W-1:0]};
  assign bk_addr   = {r_sb, r_cnt[OFF_W-1:0]};
  assign loc_wdata = r_data_q;
  assign bk_wdata  = r_data_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (w_cmd) begin
          if (w_n_in == '0)     w_state_d = StDone;
          else if (store_write) w_state_d = StLRd;
          else                  w_state_d = StBRd;
        end
      end
      StLRd:   w_state_d = StLWait;
      StLWait: w_state_d = StBWr;
      StBWr:   if (bk_ack) w_state_d = w_last ? StDone : StLRd;
      StBRd:   if (bk_ack) w_state_d = StLWr;
      StLWr:   w_state_d = w_last ? StDone : StBRd;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    store_busy = 1'b0;
    loc_we     = 1'b0;
    bk_req     = 1'b0;
    bk_we      = 1'b0;
    case (r_state)
      StIdle:         store_busy = w_cmd;
      StLRd, StLWait: store_busy = 1'b1;
      StBWr: begin
        store_busy = 1'b1;
        bk_req     = 1'b1;
        bk_we      = 1'b1;
      end
      StBRd: begin
        store_busy = 1'b1;
        bk_req     = 1'b1;
      end
      StLWr: begin
        store_busy = 1'b1;
        loc_we     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_n      <= '0;
      r_cnt    <= '0;
      r_data_q <= '0;
    end else if (w_start) begin
      r_sa  <= SA;
      r_sb  <= SB;
      r_n   <= w_n_in;
      r_cnt <= '0;
    end else begin
      case (r_state)
        StLWait: r_data_q <= loc_rdata;
        StBWr:   if (bk_ack && !w_last) r_cnt <= r_cnt + CntW'(1);
        StBRd:   if (bk_ack) r_data_q <= bk_rdata;
        StLWr:   if (!w_last) r_cnt <= r_cnt + CntW'(1);
        default: ;
      endcase
    end
  end

`ifdef STORE_CHECKSUM_EN
  logic [DATA_W-1:0] r_chk;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_chk <= '0;
    end else if (w_start) begin
      r_chk <= '0;
    end else if (((r_state == StBWr) && bk_ack) || (r_state == StLWr)) begin
      r_chk <= r_chk ^ r_data_q;
    end
  end

  assign chk = r_chk;
`else
  assign chk = '0;
`endif

endmodule

// File: tb/tb_seg_store_ctrl.sv
// Scoreboard bench for seg_store_ctrl: a word-level copy model fills an expected-event queue and a
// negedge monitor compares every backing/local transfer and completion against it.
module tb_seg_store_ctrl;

  logic        CLK, RESET;
  logic        store_write, store_read;
  logic [7:0]  SA, SB, SC;
  logic        store_busy;
  logic [11:0] loc_addr, bk_addr;
  logic        loc_we, bk_req, bk_we, bk_ack;
  logic [15:0] loc_wdata, loc_rdata, bk_wdata, bk_rdata, chk;

  seg_store_ctrl dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .store_write(store_write),
    .store_read (store_read),
    .SA         (SA),
    .SB         (SB),
    .SC         (SC),
    .store_busy (store_busy),
    .loc_addr   (loc_addr),
    .loc_we     (loc_we),
    .loc_wdata  (loc_wdata),
    .loc_rdata  (loc_rdata),
    .bk_req     (bk_req),
    .bk_we      (bk_we),
    .bk_addr    (bk_addr),
    .bk_wdata   (bk_wdata),
    .bk_rdata   (bk_rdata),
    .bk_ack     (bk_ack),
    .chk        (chk)
  );

  typedef struct {
    int kind;  // 0 bk write, 1 bk read, 2 local write, 3 done (addr=busy cycles, data=chk)
    int addr;
    int data;
  } ev_t;

  ev_t         exp_q[$];
  logic [15:0] loc_mem[4096], bk_mem[4096];
  logic [15:0] ref_loc[4096], ref_bk[4096];
  int          n_cmp = 0, n_bad = 0;
  int          bk_delay = 0;
  logic [15:0] last_chk = '0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic void chk_eq(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void check_ev(int kind, int a, int d);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind=%0d a=%0h d=%0h, expected none", kind, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.addr != a || e.data != d) begin
        n_bad++;
        $display("FAIL event: got kind=%0d a=%0h d=%0h, expected kind=%0d a=%0h d=%0h",
                 kind, a, d, e.kind, e.addr, e.data);
      end
    end
  endfunction

  // Word-level reference: what the copy must do, computed straight from the command.
  function automatic void model_push(logic wr, logic [7:0] sa, logic [7:0] sb,
                                     logic [7:0] sc, int d);
    int n, al, ab;
    logic [15:0] v, x;
    n = (sc > 8'd16) ? 16 : int'(sc);
    x = '0;
    for (int i = 0; i < n; i++) begin
      al = int'(sa) * 16 + i;
      ab = int'(sb) * 16 + i;
      if (wr) begin
        v = ref_loc[al];
        ref_bk[ab] = v;
        exp_q.push_back('{0, ab, int'(v)});
      end else begin
        v = ref_bk[ab];
        exp_q.push_back('{1, ab, 0});
        ref_loc[al] = v;
        exp_q.push_back('{2, al, int'(v)});
      end
      x = x ^ v;
    end
`ifdef STORE_CHECKSUM_EN
    last_chk = x;
`else
    last_chk = '0;
`endif
    exp_q.push_back('{3, wr ? 1 + n * (3 + d) : 1 + n * (2 + d), int'(last_chk)});
  endfunction

  task automatic wait_done_and_drop();
    bit got = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge CLK);
      if (!store_busy) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got busy=1, expected busy=0 within 2000 cycles");
    end
    @(posedge CLK);
    #1;
    store_write = 1'b0;
    store_read  = 1'b0;
    @(negedge CLK);
    chk_eq("chk_hold", int'(chk), int'(last_chk));
    chk_eq("idle_busy", int'(store_busy), 0);
  endtask

  task automatic do_cmd(logic wr, logic rd, logic [7:0] sa, logic [7:0] sb, logic [7:0] sc,
                        int d);
    model_push(wr, sa, sb, sc, d);
    bk_delay = d;
    @(posedge CLK);
    #1;
    store_write = wr;
    store_read  = rd;
    SA = sa;
    SB = sb;
    SC = sc;
    @(posedge CLK);
    #1;
    SA = 8'($urandom);
    SB = 8'($urandom);
    SC = 8'($urandom);
    wait_done_and_drop();
  endtask

  // Memory responders: local is synchronous-read; backing acks after bk_delay wait cycles.
  initial begin
    logic        c_lwe, c_req, c_ack, c_bwe;
    logic [11:0] c_la, c_ba;
    logic [15:0] c_lwd, c_bwd;
    int          wait_cnt;
    wait_cnt  = 0;
    loc_rdata = '0;
    bk_rdata  = '0;
    bk_ack    = 1'b0;
    forever begin
      @(negedge CLK);
      c_lwe = loc_we;  c_la = loc_addr; c_lwd = loc_wdata;
      c_req = bk_req;  c_ack = bk_ack;  c_bwe = bk_we;
      c_ba  = bk_addr; c_bwd = bk_wdata;
      @(posedge CLK);
      #1;
      if (c_lwe) loc_mem[c_la] = c_lwd;
      loc_rdata = loc_mem[c_la];
      if (c_req && c_ack) begin
        if (c_bwe) bk_mem[c_ba] = c_bwd;
        wait_cnt = 0;
      end
      if (bk_req) begin
        if (wait_cnt >= bk_delay) begin
          bk_ack   = 1'b1;
          bk_rdata = bk_mem[bk_addr];
        end else begin
          bk_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        bk_ack   = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Monitor: transfer events, completion, and request stability while waiting for ack.
  initial begin
    int          busy_cnt;
    logic        p_pend, p_we;
    logic [11:0] p_addr;
    logic [15:0] p_wd;
    busy_cnt = 0;
    p_pend   = 1'b0;
    p_we     = 1'b0;
    p_addr   = '0;
    p_wd     = '0;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        busy_cnt = 0;
        p_pend   = 1'b0;
      end else begin
        if (p_pend) begin
          chk_eq("req_hold", int'({bk_req, bk_we, bk_addr, bk_wdata}),
                 int'({1'b1, p_we, p_addr, p_wd}));
        end
        p_pend = bk_req && !bk_ack;
        p_we   = bk_we;
        p_addr = bk_addr;
        p_wd   = bk_wdata;
        if (bk_req && bk_ack && bk_we)  check_ev(0, int'(bk_addr), int'(bk_wdata));
        if (bk_req && bk_ack && !bk_we) check_ev(1, int'(bk_addr), 0);
        if (loc_we)                     check_ev(2, int'(loc_addr), int'(loc_wdata));
        if (store_busy) begin
          busy_cnt++;
        end else begin
          if (store_write || store_read) check_ev(3, busy_cnt, int'(chk));
          busy_cnt = 0;
        end
      end
    end
  end

  initial begin
    int diffs;
    bit seen;
    for (int i = 0; i < 4096; i++) begin
      loc_mem[i] = 16'($urandom);
      bk_mem[i]  = 16'($urandom);
    end
    loc_mem[12'h020] = 16'h00A1;
    loc_mem[12'h021] = 16'h00B2;
    loc_mem[12'h022] = 16'h00C3;
    for (int i = 0; i < 4096; i++) begin
      ref_loc[i] = loc_mem[i];
      ref_bk[i]  = bk_mem[i];
    end

    // Reset held with SAVE already decoded.
    RESET = 1'b0;
    store_write = 1'b1;
    store_read  = 1'b0;
    SA = 8'd2;
    SB = 8'd5;
    SC = 8'd3;
    bk_delay = 0;
    repeat (3) @(negedge CLK);
    chk_eq("rst_bk_req", int'(bk_req), 0);
    chk_eq("rst_bk_we", int'(bk_we), 0);
    chk_eq("rst_loc_we", int'(loc_we), 0);
    chk_eq("rst_loc_addr", int'(loc_addr), 0);
    chk_eq("rst_bk_addr", int'(bk_addr), 0);
    chk_eq("rst_loc_wdata", int'(loc_wdata), 0);
    chk_eq("rst_bk_wdata", int'(bk_wdata), 0);
    chk_eq("rst_chk", int'(chk), 0);
    model_push(1'b1, 8'd2, 8'd5, 8'd3, 0);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(negedge CLK);
    chk_eq("start_busy", int'(store_busy), 1);
    wait_done_and_drop();

    do_cmd(1'b0, 1'b1, 8'd1, 8'd7, 8'd2, 3);    // LOAD with wait states
    do_cmd(1'b1, 1'b0, 8'd9, 8'd3, 8'd0, 0);    // empty copy
    do_cmd(1'b1, 1'b0, 8'd4, 8'd6, 8'd40, 1);   // clipped to one segment
    do_cmd(1'b1, 1'b1, 8'd7, 8'd8, 8'd5, 0);    // both high -> SAVE
    do_cmd(1'b0, 1'b1, 8'd8, 8'd6, 8'd16, 2);

    for (int t = 0; t < 25; t++) begin
      logic wr, rd;
      logic [7:0] sc;
      case ($urandom_range(0, 2))
        0:       begin wr = 1'b1; rd = 1'b0; end
        1:       begin wr = 1'b0; rd = 1'b1; end
        default: begin wr = 1'b1; rd = 1'b1; end
      endcase
      sc = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 16));
      do_cmd(wr, rd, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), sc,
             $urandom_range(0, 3));
    end

    // Reset while a backing write waits for ack; nothing may complete.
    bk_delay = 50;
    @(posedge CLK);
    #1;
    store_write = 1'b1;
    SA = 8'd3;
    SB = 8'd4;
    SC = 8'd4;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (bk_req) begin
        seen = 1;
        break;
      end
    end
    chk_eq("abort_req_seen", int'(seen), 1);
    @(posedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    chk_eq("abort_bk_req", int'(bk_req), 0);
    chk_eq("abort_idle_busy", int'(store_busy), 1);
    @(negedge CLK);
    store_write = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(negedge CLK);
    chk_eq("abort_busy", int'(store_busy), 0);
    do_cmd(1'b1, 1'b0, 8'd3, 8'd4, 8'd4, 0);    // restarts at offset 0

    repeat (3) @(negedge CLK);
    chk_eq("leftover_events", exp_q.size(), 0);
    diffs = 0;
    for (int i = 0; i < 4096; i++) begin
      if (loc_mem[i] !== ref_loc[i]) diffs++;
    end
    chk_eq("loc_mem_diffs", diffs, 0);
    diffs = 0;
    for (int i = 0; i < 4096; i++) begin
      if (bk_mem[i] !== ref_bk[i]) diffs++;
    end
    chk_eq("bk_mem_diffs", diffs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_store_ctrl.md
# seg_store_ctrl

Segment store controller: the responder for the core's SAVE/LOAD store interface (store_write, store_read, SA/SB/SC, store_busy). On a command it block-copies words between core-local working memory and the backing store.
- SAVE: local segment SA -> backing segment SB.
- LOAD: backing segment SB -> local segment SA.
- SC is the word count.
- store_busy stalls the core's IP until the copy completes.

## Interface
- DATA_W, 16, word width of both memories
- SEG_W, 8, segment number width (matches SA/SB/SC)
- OFF_W, 4, word offset width; SEG_WORDS = 2**OFF_W

- CLK  in  1  clock
- RESET  in  1  reset, asynchronous, active-low
- store_write  in  1  SAVE decoded; level, held while busy
- store_read  in  1  LOAD decoded; level, held while busy
- SA  in  SEG_W  local segment number
- SB  in  SEG_W  backing segment number
- SC  in  SEG_W  word count
- store_busy  out  1  stall to core, combinational
- loc_addr  out  SEG_W+OFF_W  local address {SA_q, cnt}
- loc_we  out  1  local write strobe, one cycle
- loc_wdata  out  DATA_W  local write data
- loc_rdata  in  DATA_W  local read data, valid 1 cycle after loc_addr
- bk_req  out  1  backing request
- bk_we  out  1  backing write (1) / read (0), valid with bk_req
- bk_addr  out  SEG_W+OFF_W  backing address {SB_q, cnt}
- bk_wdata  out  DATA_W  backing write data
- bk_rdata  in  DATA_W  backing read data, valid with bk_ack
- bk_ack  in  1  backing completion, sampled at CLK rising edge
- chk  out  DATA_W  transfer checksum (see Configuration)

## Operation
- **States:** IDLE, L_RD, L_WAIT, B_WR (SAVE path); B_RD, L_WR (LOAD path); DONE.
- **Start (IDLE):** store_write or store_read high -> latch SA_q, SB_q, dir, n = min(SC, SEG_WORDS); cnt = 0.
  - n == 0 -> DONE.
  - Otherwise SAVE -> L_RD, LOAD -> B_RD.
  - Both high -> SAVE wins.
- **SAVE per word:**
  - L_RD: drive loc_addr.
  - L_WAIT: data_q <= loc_rdata.
  - B_WR: bk_req=1, bk_we=1, bk_wdata=data_q; hold until bk_ack.
  - On ack: last word -> DONE, else cnt+1 -> L_RD.
- **LOAD per word:**
  - B_RD: bk_req=1, bk_we=0; hold until bk_ack; data_q <= bk_rdata on ack.
  - L_WR: loc_we=1, loc_wdata=data_q.
  - Then last word -> DONE, else cnt+1 -> B_RD.
- **DONE:** busy low for exactly one cycle, then -> IDLE. The command is ignored in DONE even though it is still asserted; this prevents re-trigger while the core advances IP.
- **busy:** store_busy = (state != IDLE && state != DONE) || (state == IDLE && (store_write || store_read)).
- **Request rules:** bk_req, once raised, stays high with stable addr/we/wdata until bk_ack. Only RESET may drop it early.
- **Input stability:** SA/SB/SC changes after start are ignored (latched copies used).
- **Counter:** cnt is OFF_W+1 bits, so cnt never wraps. A count of SEG_WORDS transfers offsets 0..SEG_WORDS-1.
- **Reset mid-operation:** state -> IDLE, copy aborted. Words already written stay written; no rollback.

## Timing
- **Reset values:** state IDLE; loc_addr, bk_addr, loc_wdata, bk_wdata, data_q, chk = 0; loc_we, bk_req, bk_we = 0. store_busy is 0 provided no command is present.
- **store_busy:** rises in the same cycle the command is first decoded, so the core holds IP on that edge.
- **SAVE, n words, bk_ack in first request cycle:** busy high 1+3n cycles, then one DONE cycle low.
- **LOAD, n words, immediate ack:** busy high 1+2n cycles, then DONE.
- **Wait states:** each extra cycle of bk_ack delay adds one cycle per word.
- **Back-to-back commands:** earliest new command is the cycle after DONE.

## Configuration
- STORE_CHECKSUM_EN defined:
  - chk is cleared to 0 at start.
  - chk ^= each transferred word, at the B_WR ack (SAVE) or L_WR (LOAD).
  - chk holds its value after DONE until the next start.
- STORE_CHECKSUM_EN undefined: chk tied to 0, no checksum logic.

## Test plan
- Reset with store_write high -> all outputs 0, no bk_req. After release: busy=1 the same cycle, SAVE starts.
- SAVE SA=2, SB=5, SC=3, local[0x20..0x22]=A1,B2,C3, immediate ack -> bk writes to 0x50..0x52 with A1,B2,C3; busy high 10 cycles, then DONE low 1; chk=A1^B2^C3 with the macro.
- LOAD SA=1, SB=7, SC=2, bk_ack delayed 3 cycles per request -> bk_req/addr/we stable while waiting; loc_we pulses at 0x10 and 0x11; busy high 1+2*(3+1)+2 cycles.
- SC=0 -> busy high 1 cycle, DONE, no memory strobes. SC=40 -> exactly 16 words, offsets 0..15, no wrap.
- store_write and store_read both high -> SAVE performed; command held through DONE causes no second transfer.
- RESET asserted mid-B_WR -> bk_req drops immediately, state IDLE; next command restarts at cnt=0.
